// File: rtl/fft_frame_sequencer.sv
// Runs the FFT core once per frame: RAM -> FFT buffer with zero padding, start pulse, power count, frame release.
// Latency: start pulse NFFT+1 cycles after the first RAM read; release one cycle after done or timeout.
// Backpressure: none; a new frame is accepted only in IDLE while enable_i && frame_ready_i.
module fft_frame_sequencer #(
    parameter int NFFT           = 512,
    parameter int FRAME_SIZE     = 306,
    parameter int INPUT_WIDTH    = 16,
    parameter int EXP_POWER      = 257,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int PTR_W         = $clog2(NFFT),
    localparam int TMO_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable_i,
    input  logic                   frame_ready_i,
    output logic                   frame_rd_en_o,
    output logic [PTR_W-1:0]       frame_rd_addr_o,
    input  logic [INPUT_WIDTH-1:0] frame_rd_data_i,
    output logic                   frame_release_o,
    output logic                   fft_in_valid_o,
    output logic [PTR_W-1:0]       fft_frame_ptr_o,
    output logic [INPUT_WIDTH-1:0] fft_real_o,
    output logic                   fft_start_o,
    input  logic                   fft_power_valid_i,
    input  logic                   fft_done_i,
    output logic                   busy_o,
    output logic [15:0]            frame_cnt_o,
    output logic [1:0]             err_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        PAD       = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        RELEASE   = 3'd5
    } state_t;

    localparam logic [PTR_W-1:0] LAST_RD  = PTR_W'(FRAME_SIZE - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NFFT - 1);
    localparam logic [8:0]       PWR_MAX  = 9'h1FF;
    localparam logic [8:0]       PWR_EXP  = 9'(EXP_POWER);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             wr_from_ram;
    logic [8:0]       pwr_cnt;
    logic [8:0]       pwr_cnt_nxt;
    logic [TMO_W-1:0] tmo_cnt;

    // A power pulse in the done cycle must be included in the compare.
    always_comb begin
        pwr_cnt_nxt = pwr_cnt;
        if (fft_power_valid_i && (pwr_cnt != PWR_MAX))
            pwr_cnt_nxt = pwr_cnt + 9'd1;
    end

    // RAM data arrives one cycle after the read strobe, aligned with the registered write strobe/pointer.
    assign fft_real_o = wr_from_ram ? frame_rd_data_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            frame_rd_en_o   <= 1'b0;
            frame_rd_addr_o <= '0;
            frame_release_o <= 1'b0;
            fft_in_valid_o  <= 1'b0;
            fft_frame_ptr_o <= '0;
            wr_from_ram     <= 1'b0;
            fft_start_o     <= 1'b0;
            busy_o          <= 1'b0;
            frame_cnt_o     <= '0;
            err_o           <= '0;
            pwr_cnt         <= '0;
            tmo_cnt         <= '0;
        end else begin
            frame_rd_en_o   <= 1'b0;
            fft_in_valid_o  <= 1'b0;
            wr_from_ram     <= 1'b0;
            fft_start_o     <= 1'b0;
            frame_release_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable_i && frame_ready_i) begin
                        state           <= LOAD;
                        busy_o          <= 1'b1;
                        frame_rd_en_o   <= 1'b1;
                        frame_rd_addr_o <= '0;
                        pwr_cnt         <= '0;
                    end
                end
                LOAD: begin
                    fft_in_valid_o  <= 1'b1;
                    wr_from_ram     <= 1'b1;
                    fft_frame_ptr_o <= frame_rd_addr_o;
                    if (frame_rd_addr_o == LAST_RD) begin
                        state <= PAD;
                    end else begin
                        frame_rd_en_o   <= 1'b1;
                        frame_rd_addr_o <= frame_rd_addr_o + PTR_W'(1);
                    end
                end
                // First PAD cycle carries the last RAM sample; padding continues from the next slot.
                PAD: begin
                    if (fft_frame_ptr_o == LAST_PTR) begin
                        state           <= START;
                        fft_start_o     <= 1'b1;
                        fft_frame_ptr_o <= '0;
                    end else begin
                        fft_in_valid_o  <= 1'b1;
                        fft_frame_ptr_o <= fft_frame_ptr_o + PTR_W'(1);
                    end
                end
                START: begin
                    state   <= WAIT_DONE;
                    tmo_cnt <= '0;
                end
                WAIT_DONE: begin
                    pwr_cnt <= pwr_cnt_nxt;
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (fft_done_i) begin
                        if (pwr_cnt_nxt == PWR_EXP)
                            frame_cnt_o <= frame_cnt_o + 16'd1;
                        else
                            err_o[1] <= 1'b1;
                        state           <= RELEASE;
                        frame_release_o <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_o[0]        <= 1'b1;
                        state           <= RELEASE;
                        frame_release_o <= 1'b1;
                    end
                end
                RELEASE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed + randomized bench for fft_frame_sequencer: RAM and FFT models, write-stream capture, frame-level reference.
module tb_fft_frame_sequencer;

    localparam int NFFT           = 512;
    localparam int FRAME_SIZE     = 306;
    localparam int INPUT_WIDTH    = 16;
    localparam int EXP_POWER      = 257;
    localparam int TIMEOUT_CYCLES = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        frame_ready_i = 1'b0;
    logic        frame_rd_en_o;
    logic [8:0]  frame_rd_addr_o;
    logic [15:0] frame_rd_data_i = 16'h0;
    logic        frame_release_o;
    logic        fft_in_valid_o;
    logic [8:0]  fft_frame_ptr_o;
    logic [15:0] fft_real_o;
    logic        fft_start_o;
    logic        fft_power_valid_i;
    logic        fft_done_i;
    logic        busy_o;
    logic [15:0] frame_cnt_o;
    logic [1:0]  err_o;

    logic model_pwr = 1'b0, model_done = 1'b0, spur_pwr = 1'b0, spur_done = 1'b0;
    assign fft_power_valid_i = model_pwr | spur_pwr;
    assign fft_done_i        = model_done | spur_done;

    int checks = 0;
    int errors = 0;

    fft_frame_sequencer #(
        .NFFT(NFFT), .FRAME_SIZE(FRAME_SIZE), .INPUT_WIDTH(INPUT_WIDTH),
        .EXP_POWER(EXP_POWER), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .frame_ready_i(frame_ready_i),
        .frame_rd_en_o(frame_rd_en_o), .frame_rd_addr_o(frame_rd_addr_o),
        .frame_rd_data_i(frame_rd_data_i), .frame_release_o(frame_release_o),
        .fft_in_valid_o(fft_in_valid_o), .fft_frame_ptr_o(fft_frame_ptr_o),
        .fft_real_o(fft_real_o), .fft_start_o(fft_start_o),
        .fft_power_valid_i(fft_power_valid_i), .fft_done_i(fft_done_i),
        .busy_o(busy_o), .frame_cnt_o(frame_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Frame RAM with one-cycle read latency.
    logic [15:0] ram [NFFT];
    always @(posedge clk) if (frame_rd_en_o) frame_rd_data_i <= ram[frame_rd_addr_o];

    // Observation of everything the DUT emits, sampled mid-cycle.
    int cyc = 0;
    int n_rd = 0, bad_rd = 0, n_start = 0, n_rel = 0, overlap = 0;
    int first_rd_cyc = 0, start_cyc = 0, rel_cyc = 0;
    logic [24:0] wq [$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fft_in_valid_o) wq.push_back({fft_frame_ptr_o, fft_real_o});
        if (frame_rd_en_o) begin
            n_rd++;
            if (frame_rd_addr_o >= 9'(FRAME_SIZE)) bad_rd++;
            if (frame_rd_addr_o == 9'd0) first_rd_cyc = cyc;
        end
        if (fft_start_o) begin
            n_start++;
            start_cyc = cyc;
            if (fft_in_valid_o) overlap++;
        end
        if (frame_release_o) begin
            n_rel++;
            rel_cyc = cyc;
        end
    end

    // FFT model: after each start, m_npwr power pulses then (optionally) done.
    int m_npwr = EXP_POWER;
    bit m_done = 1'b1;
    bit m_same = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && fft_start_o) begin
                for (int i = 0; i < m_npwr && rst_n; i++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    model_pwr = 1'b1;
                    if (i == m_npwr - 1 && m_done && m_same) model_done = 1'b1;
                    @(negedge clk);
                    model_pwr  = 1'b0;
                    model_done = 1'b0;
                end
                if (m_done && !(m_same && m_npwr > 0) && rst_n) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    model_done = 1'b1;
                    @(negedge clk);
                    model_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 200000", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Frame-level reference: NFFT writes, RAM samples then zeros, one start, one release, counter/flags by rule.
    logic [24:0] exp_words [NFFT];
    logic [15:0] exp_cnt = 16'd0;
    logic [1:0]  exp_err = 2'b00;
    int base = 0, rel0 = 0, st0 = 0, rd0 = 0;

    task automatic begin_frame(input int npwr, input bit give_done, input bit same);
        m_npwr = npwr;
        m_done = give_done;
        m_same = same;
        for (int k = 0; k < NFFT; k++)
            exp_words[k] = {9'(k), (k < FRAME_SIZE) ? ram[k] : 16'h0};
        if (give_done) begin
            if (npwr == EXP_POWER) exp_cnt = exp_cnt + 16'd1;
            else exp_err[1] = 1'b1;
        end else begin
            exp_err[0] = 1'b1;
        end
        base = wq.size();
        rel0 = n_rel;
        st0  = n_start;
        rd0  = n_rd;
        frame_ready_i = 1'b1;
    endtask

    task automatic finish_frame(input string tag, input bit keep_ready);
        int budget = TIMEOUT_CYCLES + 4000;
        while (n_rel == rel0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!keep_ready) frame_ready_i = 1'b0;
        chk({tag, " release_within_budget"}, 64'(budget > 0), 64'd1);
        chk({tag, " write_count"}, 64'(wq.size() - base), 64'(NFFT));
        for (int k = 0; k < NFFT; k++)
            if (base + k < wq.size())
                chk($sformatf("%s write%0d {ptr,data}", tag, k), 64'(wq[base + k]), 64'(exp_words[k]));
        chk({tag, " read_count"}, 64'(n_rd - rd0), 64'(FRAME_SIZE));
        chk({tag, " read_addr_range"}, 64'(bad_rd), 64'd0);
        chk({tag, " start_pulses"}, 64'(n_start - st0), 64'd1);
        chk({tag, " release_pulses"}, 64'(n_rel - rel0), 64'd1);
        chk({tag, " start_latency"}, 64'(start_cyc - first_rd_cyc), 64'(NFFT + 1));
        chk({tag, " start_with_write"}, 64'(overlap), 64'd0);
        chk({tag, " frame_cnt"}, 64'(frame_cnt_o), 64'(exp_cnt));
        chk({tag, " err"}, 64'(err_o), 64'(exp_err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {frame_rd_en_o, frame_rd_addr_o, frame_release_o, fft_in_valid_o,
            fft_frame_ptr_o, fft_real_o, fft_start_o, busy_o, frame_cnt_o, err_o}, 64'd0);
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        exp_err = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic fill_ram(input bit ramp);
        for (int k = 0; k < NFFT; k++) ram[k] = ramp ? 16'(k + 1) : 16'($urandom);
    endtask

    initial begin
        int budget;
        int prev_rel;
        logic [63:0] snap;

        fill_ram(1'b1);
        do_reset();
        enable_i = 1'b1;

        // Nominal frame with ramp data.
        begin_frame(EXP_POWER, 1'b1, 1'b0);
        finish_frame("t1", 1'b0);

        // Spurious done/power outside WAIT_DONE: once in IDLE, once during LOAD.
        spur_done = 1'b1; spur_pwr = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0; spur_pwr = 1'b0;
        chk("t7 idle_spurious busy", 64'(busy_o), 64'd0);
        chk("t7 idle_spurious err", 64'(err_o), 64'(exp_err));
        fill_ram(1'b1);
        begin_frame(EXP_POWER, 1'b1, 1'b1);
        budget = 100;
        while (!frame_rd_en_o && budget > 0) begin @(posedge clk); #1; budget--; end
        repeat ($urandom_range(5, 50)) @(posedge clk);
        #1;
        spur_done = 1'b1; spur_pwr = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0; spur_pwr = 1'b0;
        finish_frame("t7", 1'b0);

        // Back-to-back frames with frame_ready_i held high.
        snap = 64'(frame_cnt_o);
        prev_rel = 0;
        for (int f = 0; f < 3; f++) begin
            fill_ram(1'b0);
            begin_frame(EXP_POWER, 1'b1, 1'($urandom));
            finish_frame($sformatf("t2 frame%0d", f), f < 2);
            if (f > 0) chk($sformatf("t2 idle_gap%0d", f), 64'(first_rd_cyc - prev_rel), 64'd2);
            prev_rel = rel_cyc;
        end
        chk("t2 frame_cnt_delta", 64'(frame_cnt_o) - snap, 64'd3);

        // Asynchronous reset in the middle of the write stream.
        frame_ready_i = 1'b1;
        rel0 = n_rel;
        budget = 2000;
        while (!(fft_in_valid_o && fft_frame_ptr_o == 9'd100) && budget > 0) begin
            @(posedge clk); #1; budget--;
        end
        chk("t5 reached_ptr100", 64'(budget > 0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5 outputs_in_reset", {frame_rd_en_o, frame_rd_addr_o, frame_release_o, fft_in_valid_o,
            fft_frame_ptr_o, fft_real_o, fft_start_o, busy_o, frame_cnt_o, err_o}, 64'd0);
        frame_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        exp_err = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        chk("t5 no_release", 64'(n_rel - rel0), 64'd0);
        chk("t5 idle_after_reset", 64'(busy_o), 64'd0);
        fill_ram(1'b0);
        begin_frame(EXP_POWER, 1'b1, 1'($urandom));
        finish_frame("t5 restart", 1'b0);

        // Acceptance gated by enable_i.
        enable_i = 1'b0;
        fill_ram(1'b0);
        begin_frame(EXP_POWER, 1'b1, 1'b0);
        repeat (1000) @(posedge clk);
        #1;
        chk("t6 no_read_while_disabled", 64'(n_rd - rd0), 64'd0);
        chk("t6 idle_while_disabled", 64'(busy_o), 64'd0);
        enable_i = 1'b1;
        @(posedge clk); #1;
        chk("t6 load_next_cycle", {frame_rd_en_o, frame_rd_addr_o}, {1'b1, 9'd0});
        finish_frame("t6", 1'b0);

        // Power-count mismatch.
        do_reset();
        fill_ram(1'b0);
        begin_frame(EXP_POWER - 1, 1'b1, 1'($urandom));
        finish_frame("t4", 1'b0);

        // Done never arrives.
        do_reset();
        fill_ram(1'b0);
        begin_frame($urandom_range(0, 300), 1'b0, 1'b0);
        finish_frame("t3", 1'b0);
        chk("t3 wait_done_cycles", 64'(rel_cyc - start_cyc), 64'(TIMEOUT_CYCLES + 1));

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
